multicycle_control_unit: RTL and testbench
==========================================

Name: multicycle_control_unit

Overview:
Multi-cycle successor to the single-cycle opcode decoder in the 16-bit CPU. Sequences every instruction through FETCH/DECODE/EXECUTE/MEM/WRITEBACK and drives the same datapath controls (RegDst, ALUSrc, MemToReg, RegWrite, MemRead, MemWrite, ALUOp, Branch), plus PC/IR write enables. Adds a ready handshake for variable-latency memory, a wait-state timeout, and an illegal-opcode trap. Parametrised in opcode width and timeout depth.

Parameters:
OPCODE_WIDTH, 3, opcode field width; values with any bit above bit 2 set are illegal
TIMEOUT_CYCLES, 15, max wait cycles for MemReady before trapping (must be >= 1)
CNT_WIDTH, 4, wait-counter width; must satisfy 2^CNT_WIDTH > TIMEOUT_CYCLES

Ports:
Clock  input  1  system clock, rising edge
Reset_n  input  1  asynchronous, active-low reset
Enable  input  1  permits a new fetch; sampled only in FETCH
OPCODE  input  OPCODE_WIDTH  opcode from instruction register; sampled in DECODE
MemReady  input  1  memory completes the current read/write this cycle
RegDst  output  1  destination register select (1 = rd)
ALUSrc  output  1  ALU B operand: 1 = immediate
MemToReg  output  1  write-back source: 1 = memory data
RegWrite  output  1  register file write enable
MemRead  output  1  memory read request (fetch or LW)
MemWrite  output  1  memory write request (SW)
ALUOp  output  2  00 add, 01 subtract/compare, 10 funct-decoded, 11 immediate op
Branch  output  1  BNE branch qualify
PCWrite  output  1  PC increment enable
IRWrite  output  1  instruction register load
Trap  output  1  sticky fault flag
TrapCause  output  2  00 none, 01 illegal opcode, 10 fetch timeout, 11 data timeout
State  output  3  current state encoding, for debug

Behaviour:
- Opcode map: 000 R-type (XOR/SUB/MOD); 001 ANDI; 010 ORI; 011 ADDI; 100 SLTI; 101 LW; 110 SW; 111 BNE.
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7. All state registers use async reset only; no synchronous reset path.
- Reset (Reset_n low, asynchronous): state=FETCH, latched opcode=0, wait counter=0, Trap=0, TrapCause=00. All outputs 0. Deassertion takes effect on the next rising edge. Reset mid-instruction aborts it; no memory request is asserted in the reset cycle.
- FETCH: if Enable=0, remain in FETCH with all outputs 0 and counter cleared.
  - If Enable=1: MemRead=1. When MemReady=1 in the same cycle, IRWrite=1 and PCWrite=1 (Mealy, that cycle only), then go to DECODE.
  - Otherwise the counter increments. If MemReady is still 0 when the counter equals TIMEOUT_CYCLES, go to TRAP with cause 10.
- DECODE (1 cycle): latch OPCODE into an internal register. All datapath controls are 0. An illegal opcode goes to TRAP with cause 01; otherwise go to EXEC.
- EXEC (1 cycle): ALUSrc and ALUOp are driven from the latched opcode.
  - R-type: ALUSrc=0, ALUOp=10.
  - ANDI, ORI, ADDI, SLTI: ALUSrc=1, ALUOp=11.
  - LW, SW: ALUSrc=1, ALUOp=00.
  - BNE: ALUSrc=0, ALUOp=01, Branch=1 for this cycle only.
  - Next state: BNE goes to FETCH; LW/SW go to MEM (counter cleared); all others go to WB.
- MEM: ALUSrc=1, ALUOp=00 held. LW drives MemRead=1; SW drives MemWrite=1; both held until MemReady.
  - On MemReady: LW goes to WB; SW goes to FETCH.
  - Same timeout rule as FETCH, with cause 11.
- WB (1 cycle): RegWrite=1. R-type: RegDst=1, MemToReg=0. LW: RegDst=0, MemToReg=1. I-type: RegDst=0, MemToReg=0. Then go to FETCH.
- TRAP: all datapath controls 0, Trap=1, TrapCause held. Exit only via reset.
- Counter saturates and never wraps. It clears on every state change.
- MemRead and MemWrite are never asserted together. RegWrite is asserted only in WB.
- Latency in cycles with MemReady always 1: R/I-type 4, LW 5, SW 4, BNE 3.

Test Plan:
- Reset then ADDI (011), MemReady=1, Enable=1 -> State 0,1,2,4,0. IRWrite/PCWrite high in cycle 1 only; ALUSrc=1, ALUOp=11 in EXEC; RegWrite=1, RegDst=0 in WB.
- LW (101) with MemReady delayed 3 cycles in MEM -> MemRead held 4 cycles in MEM. WB then has MemToReg=1, RegWrite=1. Total 8 cycles.
- SW (110) then BNE (111) -> SW: MemWrite=1 in MEM, no RegWrite at any point. BNE: Branch=1, ALUOp=01 for exactly one cycle, back to FETCH after 3 cycles.
- OPCODE_WIDTH=4, opcode 4'b1000 -> DECODE goes to TRAP. Trap=1, TrapCause=01; outputs stay 0 for 20 cycles; Reset_n pulse returns to FETCH with Trap=0.
- TIMEOUT_CYCLES=3, MemReady=0 in FETCH -> TRAP after exactly 4 FETCH cycles, TrapCause=10. Repeating in MEM for LW gives TrapCause=11.
- Reset_n pulled low asynchronously mid-MEM of SW -> MemWrite drops to 0 before the next clock edge; after release, Enable=0 holds FETCH with all outputs 0.

Source files
------------

// File: rtl/multicycle_control_unit_if.sv
// Bundle of signals between the multi-cycle control unit and the datapath /
// memory side of the 16-bit CPU.
//
// Parameters:
//   OPCODE_WIDTH  width of the opcode field coming from the instruction register
//
// Signals:
//   enable      permits a new instruction fetch
//   opcode      opcode from the instruction register
//   mem_ready   memory finishes the current read/write this cycle
//   reg_dst     destination register select (1 = rd)
//   alu_src     ALU B operand select (1 = immediate)
//   mem_to_reg  write-back source select (1 = memory data)
//   reg_write   register file write enable
//   mem_read    memory read request (fetch or LW)
//   mem_write   memory write request (SW)
//   alu_op      00 add, 01 subtract/compare, 10 funct-decoded, 11 immediate op
//   branch      BNE branch qualify
//   pc_write    PC increment enable
//   ir_write    instruction register load
//   trap        sticky fault flag
//   trap_cause  00 none, 01 illegal opcode, 10 fetch timeout, 11 data timeout
//   state       current controller state, for debug
//
// Modports:
//   master  the control unit (drives the controls, receives opcode/handshake)
//   slave   the datapath / memory side
`timescale 1ns/1ps
interface multicycle_control_unit_if #(
  parameter int OPCODE_WIDTH = 3
);
  logic                    enable;
  logic [OPCODE_WIDTH-1:0] opcode;
  logic                    mem_ready;
  logic                    reg_dst;
  logic                    alu_src;
  logic                    mem_to_reg;
  logic                    reg_write;
  logic                    mem_read;
  logic                    mem_write;
  logic [1:0]              alu_op;
  logic                    branch;
  logic                    pc_write;
  logic                    ir_write;
  logic                    trap;
  logic [1:0]              trap_cause;
  logic [2:0]              state;

  modport master (
    input  enable, opcode, mem_ready,
    output reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write,
           alu_op, branch, pc_write, ir_write, trap, trap_cause, state
  );

  modport slave (
    output enable, opcode, mem_ready,
    input  reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write,
           alu_op, branch, pc_write, ir_write, trap, trap_cause, state
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multi-cycle control unit for the 16-bit CPU. Steps each instruction
// through FETCH / DECODE / EXEC / MEM / WB, drives the datapath controls,
// waits on a memory ready handshake with a bounded wait, and traps on
// illegal opcodes or memory timeouts. The trap is left only through reset.
//
// Parameters:
//   OPCODE_WIDTH    opcode field width; any set bit above bit 2 is illegal
//   TIMEOUT_CYCLES  wait cycles tolerated on mem_ready before trapping (>= 1)
//   CNT_WIDTH       wait counter width, 2**CNT_WIDTH > TIMEOUT_CYCLES
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    control/handshake bundle (master side)
`timescale 1ns/1ps
module multicycle_control_unit #(
  parameter int OPCODE_WIDTH   = 3,
  parameter int TIMEOUT_CYCLES = 15,
  parameter int CNT_WIDTH      = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  multicycle_control_unit_if.master   bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_t;

  localparam logic [2:0] OP_RTYPE = 3'd0;
  localparam logic [2:0] OP_LW    = 3'd5;
  localparam logic [2:0] OP_SW    = 3'd6;
  localparam logic [2:0] OP_BNE   = 3'd7;

  localparam logic [CNT_WIDTH-1:0] CNT_LIMIT = CNT_WIDTH'(TIMEOUT_CYCLES);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

  state_t                  state_q, state_d;
  logic [2:0]              op_q;
  logic [CNT_WIDTH-1:0]    cnt_q;
  logic [1:0]              cause_q, cause_d;
  logic                    waiting;
  logic [OPCODE_WIDTH-1:0] op_hi;
  logic                    op_illegal;

  // Anything set above the three architected opcode bits is an illegal opcode.
  assign op_hi      = bus.opcode >> 3;
  assign op_illegal = (op_hi != '0);

  // State, latched opcode, trap cause and wait counter. The counter only
  // counts while the controller is stalled on mem_ready in the same state,
  // saturates instead of wrapping, and is zero after any state change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      op_q    <= 3'd0;
      cnt_q   <= '0;
      cause_q <= 2'b00;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      if (state_q == S_DECODE) begin
        op_q <= bus.opcode[2:0];
      end
      if (waiting && (state_d == state_q)) begin
        if (cnt_q != CNT_MAX) begin
          cnt_q <= cnt_q + 1'b1;
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  // Next-state and control decode. The fetch handshake (ir_write/pc_write)
  // is Mealy on mem_ready. Every output is forced low while reset is held so
  // that no memory request is issued in the reset cycle, even though the
  // state register already reads FETCH.
  always_comb begin
    state_d        = state_q;
    cause_d        = cause_q;
    waiting        = 1'b0;
    bus.reg_dst    = 1'b0;
    bus.alu_src    = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.reg_write  = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.alu_op     = 2'b00;
    bus.branch     = 1'b0;
    bus.pc_write   = 1'b0;
    bus.ir_write   = 1'b0;
    bus.trap       = 1'b0;
    bus.trap_cause = cause_q;
    bus.state      = state_q;

    case (state_q)
      S_FETCH: begin
        if (bus.enable) begin
          bus.mem_read = 1'b1;
          if (bus.mem_ready) begin
            bus.ir_write = 1'b1;
            bus.pc_write = 1'b1;
            state_d      = S_DECODE;
          end else begin
            waiting = 1'b1;
            if (cnt_q == CNT_LIMIT) begin
              state_d = S_TRAP;
              cause_d = 2'b10;
            end
          end
        end
      end

      S_DECODE: begin
        if (op_illegal) begin
          state_d = S_TRAP;
          cause_d = 2'b01;
        end else begin
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        case (op_q)
          OP_RTYPE: begin
            bus.alu_op = 2'b10;
            state_d    = S_WB;
          end
          OP_LW, OP_SW: begin
            bus.alu_src = 1'b1;
            bus.alu_op  = 2'b00;
            state_d     = S_MEM;
          end
          OP_BNE: begin
            bus.alu_op = 2'b01;
            bus.branch = 1'b1;
            state_d    = S_FETCH;
          end
          default: begin
            bus.alu_src = 1'b1;
            bus.alu_op  = 2'b11;
            state_d     = S_WB;
          end
        endcase
      end

      S_MEM: begin
        bus.alu_src = 1'b1;
        if (op_q == OP_LW) begin
          bus.mem_read = 1'b1;
        end else begin
          bus.mem_write = 1'b1;
        end
        if (bus.mem_ready) begin
          state_d = (op_q == OP_LW) ? S_WB : S_FETCH;
        end else begin
          waiting = 1'b1;
          if (cnt_q == CNT_LIMIT) begin
            state_d = S_TRAP;
            cause_d = 2'b11;
          end
        end
      end

      S_WB: begin
        bus.reg_write  = 1'b1;
        bus.reg_dst    = (op_q == OP_RTYPE);
        bus.mem_to_reg = (op_q == OP_LW);
        state_d        = S_FETCH;
      end

      S_TRAP: begin
        bus.trap = 1'b1;
      end

      default: begin
        state_d = S_FETCH;
      end
    endcase

    if (!rst_n) begin
      bus.reg_dst    = 1'b0;
      bus.alu_src    = 1'b0;
      bus.mem_to_reg = 1'b0;
      bus.reg_write  = 1'b0;
      bus.mem_read   = 1'b0;
      bus.mem_write  = 1'b0;
      bus.alu_op     = 2'b00;
      bus.branch     = 1'b0;
      bus.pc_write   = 1'b0;
      bus.ir_write   = 1'b0;
      bus.trap       = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit. The stimulus thread drives
// one cycle of inputs at a time and queues the hand-computed state/control
// vector expected for that cycle; a monitor on the falling edge pops and
// compares. The DUT uses a 4-bit opcode and a 3-cycle timeout so the
// illegal-opcode and timeout boundaries are reachable quickly.
`timescale 1ns/1ps
module tb_multicycle_control_unit;

  localparam logic [2:0] ST_F = 3'd0;
  localparam logic [2:0] ST_D = 3'd1;
  localparam logic [2:0] ST_E = 3'd2;
  localparam logic [2:0] ST_M = 3'd3;
  localparam logic [2:0] ST_W = 3'd4;
  localparam logic [2:0] ST_T = 3'd7;

  localparam logic [13:0] C_NONE   = 14'h0000;
  localparam logic [13:0] C_RD     = 14'h2000;
  localparam logic [13:0] C_AS     = 14'h1000;
  localparam logic [13:0] C_MTR    = 14'h0800;
  localparam logic [13:0] C_RW     = 14'h0400;
  localparam logic [13:0] C_MR     = 14'h0200;
  localparam logic [13:0] C_MW     = 14'h0100;
  localparam logic [13:0] C_OP_FN  = 14'h0080;
  localparam logic [13:0] C_OP_SUB = 14'h0040;
  localparam logic [13:0] C_OP_IMM = 14'h00C0;
  localparam logic [13:0] C_BR     = 14'h0020;
  localparam logic [13:0] C_PCW    = 14'h0010;
  localparam logic [13:0] C_IRW    = 14'h0008;
  localparam logic [13:0] C_TRAP   = 14'h0004;
  localparam logic [13:0] C_TC_ILL = 14'h0001;
  localparam logic [13:0] C_TC_FET = 14'h0002;
  localparam logic [13:0] C_TC_DAT = 14'h0003;
  localparam logic [13:0] C_FETCH  = C_MR | C_PCW | C_IRW;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  logic [16:0] expQ[$];
  string       nameQ[$];

  multicycle_control_unit_if #(.OPCODE_WIDTH(4)) bus ();

  multicycle_control_unit #(
    .OPCODE_WIDTH(4),
    .TIMEOUT_CYCLES(3),
    .CNT_WIDTH(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [16:0] sampleDut();
    return {bus.state, bus.reg_dst, bus.alu_src, bus.mem_to_reg, bus.reg_write,
            bus.mem_read, bus.mem_write, bus.alu_op, bus.branch, bus.pc_write,
            bus.ir_write, bus.trap, bus.trap_cause};
  endfunction

  task automatic checkOutput(input string name, input logic [16:0] expv);
    logic [16:0] act;
    act = sampleDut();
    checks++;
    if (act !== expv) begin
      failures++;
      $display("[TB] FAIL %s: actual state=%0d ctl=%b, expected state=%0d ctl=%b",
               name, act[16:14], act[13:0], expv[16:14], expv[13:0]);
    end
  endtask

  // Drive one cycle of inputs just after the rising edge and queue the
  // vector expected for that cycle.
  task automatic applyStimulus(input string name, input logic en, input logic [3:0] op,
                               input logic rdy, input logic [2:0] st, input logic [13:0] ctl);
    @(posedge clk);
    #1;
    bus.enable    = en;
    bus.opcode    = op;
    bus.mem_ready = rdy;
    expQ.push_back({st, ctl});
    nameQ.push_back(name);
  endtask

  // Drop reset between edges and check the outputs collapse immediately,
  // then hold reset across one rising edge and release with inputs idle.
  task automatic resetPulse(input string name);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput(name, {ST_F, C_NONE});
    bus.enable    = 1'b0;
    bus.opcode    = 4'h0;
    bus.mem_ready = 1'b0;
    @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Scoreboard monitor: compare every queued expectation mid-cycle.
  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      checkOutput(nameQ.pop_front(), expQ.pop_front());
    end
  end

  // Hard stop in case the stimulus thread ever stalls.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: actual=time limit reached, required=stimulus complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks        = 0;
    failures      = 0;
    rst_n         = 1'b0;
    bus.enable    = 1'b0;
    bus.opcode    = 4'h0;
    bus.mem_ready = 1'b0;

    applyStimulus("reset_no_request", 1'b1, 4'b0011, 1'b1, ST_F, C_NONE);
    applyStimulus("reset_idle",       1'b0, 4'b0000, 1'b0, ST_F, C_NONE);
    @(negedge clk);
    #1;
    rst_n = 1'b1;

    applyStimulus("addi_fetch",  1'b1, 4'b0011, 1'b1, ST_F, C_FETCH);
    applyStimulus("addi_decode", 1'b1, 4'b0011, 1'b1, ST_D, C_NONE);
    applyStimulus("addi_exec",   1'b1, 4'b0011, 1'b1, ST_E, C_AS | C_OP_IMM);
    applyStimulus("addi_wb",     1'b1, 4'b0011, 1'b1, ST_W, C_RW);
    applyStimulus("addi_idle",   1'b0, 4'b0011, 1'b1, ST_F, C_NONE);

    applyStimulus("rtype_fetch",  1'b1, 4'b0000, 1'b1, ST_F, C_FETCH);
    applyStimulus("rtype_decode", 1'b1, 4'b0000, 1'b1, ST_D, C_NONE);
    applyStimulus("rtype_exec",   1'b1, 4'b0000, 1'b1, ST_E, C_OP_FN);
    applyStimulus("rtype_wb",     1'b1, 4'b0000, 1'b1, ST_W, C_RD | C_RW);
    applyStimulus("rtype_idle",   1'b0, 4'b0000, 1'b1, ST_F, C_NONE);

    applyStimulus("lw_fetch",  1'b1, 4'b0101, 1'b1, ST_F, C_FETCH);
    applyStimulus("lw_decode", 1'b1, 4'b0101, 1'b1, ST_D, C_NONE);
    applyStimulus("lw_exec",   1'b1, 4'b0101, 1'b1, ST_E, C_AS);
    for (int i = 0; i < 3; i++) begin
      applyStimulus($sformatf("lw_mem_wait%0d", i), 1'b1, 4'b0101, 1'b0, ST_M, C_AS | C_MR);
    end
    applyStimulus("lw_mem_ready", 1'b1, 4'b0101, 1'b1, ST_M, C_AS | C_MR);
    applyStimulus("lw_wb",        1'b1, 4'b0101, 1'b1, ST_W, C_RW | C_MTR);
    applyStimulus("lw_idle",      1'b0, 4'b0101, 1'b1, ST_F, C_NONE);

    applyStimulus("sw_fetch",   1'b1, 4'b0110, 1'b1, ST_F, C_FETCH);
    applyStimulus("sw_decode",  1'b1, 4'b0110, 1'b1, ST_D, C_NONE);
    applyStimulus("sw_exec",    1'b1, 4'b0110, 1'b1, ST_E, C_AS);
    applyStimulus("sw_mem",     1'b1, 4'b0110, 1'b1, ST_M, C_AS | C_MW);
    applyStimulus("bne_fetch",  1'b1, 4'b0111, 1'b1, ST_F, C_FETCH);
    applyStimulus("bne_decode", 1'b1, 4'b0111, 1'b1, ST_D, C_NONE);
    applyStimulus("bne_exec",   1'b1, 4'b0111, 1'b1, ST_E, C_OP_SUB | C_BR);
    applyStimulus("bne_idle",   1'b0, 4'b0111, 1'b1, ST_F, C_NONE);

    applyStimulus("ill_fetch",  1'b1, 4'b1000, 1'b1, ST_F, C_FETCH);
    applyStimulus("ill_decode", 1'b1, 4'b1000, 1'b1, ST_D, C_NONE);
    for (int i = 0; i < 20; i++) begin
      applyStimulus($sformatf("ill_trap%0d", i), 1'b1, 4'b0101, i[0], ST_T, C_TRAP | C_TC_ILL);
    end
    resetPulse("ill_reset");
    applyStimulus("ill_after_reset", 1'b0, 4'b0000, 1'b0, ST_F, C_NONE);

    for (int i = 0; i < 4; i++) begin
      applyStimulus($sformatf("ftimeout_wait%0d", i), 1'b1, 4'b0011, 1'b0, ST_F, C_MR);
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus($sformatf("ftimeout_trap%0d", i), 1'b1, 4'b0011, 1'b1, ST_T, C_TRAP | C_TC_FET);
    end
    resetPulse("ftimeout_reset");
    applyStimulus("ftimeout_after_reset", 1'b0, 4'b0000, 1'b0, ST_F, C_NONE);

    applyStimulus("dtimeout_fetch",  1'b1, 4'b0101, 1'b1, ST_F, C_FETCH);
    applyStimulus("dtimeout_decode", 1'b1, 4'b0101, 1'b1, ST_D, C_NONE);
    applyStimulus("dtimeout_exec",   1'b1, 4'b0101, 1'b0, ST_E, C_AS);
    for (int i = 0; i < 4; i++) begin
      applyStimulus($sformatf("dtimeout_wait%0d", i), 1'b1, 4'b0101, 1'b0, ST_M, C_AS | C_MR);
    end
    for (int i = 0; i < 2; i++) begin
      applyStimulus($sformatf("dtimeout_trap%0d", i), 1'b1, 4'b0101, 1'b1, ST_T, C_TRAP | C_TC_DAT);
    end
    resetPulse("dtimeout_reset");
    applyStimulus("dtimeout_after_reset", 1'b0, 4'b0000, 1'b0, ST_F, C_NONE);

    applyStimulus("swrst_fetch",  1'b1, 4'b0110, 1'b1, ST_F, C_FETCH);
    applyStimulus("swrst_decode", 1'b1, 4'b0110, 1'b1, ST_D, C_NONE);
    applyStimulus("swrst_exec",   1'b1, 4'b0110, 1'b0, ST_E, C_AS);
    applyStimulus("swrst_mem0",   1'b1, 4'b0110, 1'b0, ST_M, C_AS | C_MW);
    applyStimulus("swrst_mem1",   1'b1, 4'b0110, 1'b0, ST_M, C_AS | C_MW);
    resetPulse("swrst_async_drop");
    for (int i = 0; i < 3; i++) begin
      applyStimulus($sformatf("swrst_idle%0d", i), 1'b0, 4'b0110, 1'b1, ST_F, C_NONE);
    end

    @(negedge clk);
    #1;
    checks++;
    if (expQ.size() != 0) begin
      failures++;
      $display("[TB] FAIL drain: actual=%0d pending, required=0 pending", expQ.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
